// File: rtl/pipe_pkg.sv
// Shared encodings and the stage control bundle for the CONTROL/pipeline tracker.
// CONTROL decodes against the same REWR_* values carried here.
package pipe_pkg;

    typedef enum logic [1:0] {
        REWR_NONE = 2'b00,
        REWR_LOAD = 2'b01,
        REWR_ALU  = 2'b10,
        REWR_BR   = 2'b11
    } rewr_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_e;

    // Register-address fields travel beside this bundle so their width can follow REG_AW.
    typedef struct packed {
        logic  valid;
        logic  rf_we;
        logic  d_mem_wen;
        rewr_e rewr_mux;
        logic  numinst;
    } stage_ctrl_t;

    localparam int CTRL_W = $bits(stage_ctrl_t);

    localparam stage_ctrl_t BUBBLE = '{
        valid:     1'b0,
        rf_we:     1'b0,
        d_mem_wen: 1'b1,
        rewr_mux:  REWR_NONE,
        numinst:   1'b0
    };

endpackage

// File: rtl/pipe_ctrl_stage.sv
// One pipeline stage register for the control bundle plus its register-address payload.
// A bubble clears the payload too, so an empty stage never looks like a hazard source.
module pipe_ctrl_stage
    import pipe_pkg::*;
#(
    parameter int PW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bubble,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [PW-1:0]     d_pay,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [PW-1:0]     q_pay
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_ctrl <= BUBBLE;
            q_pay  <= '0;
        end else if (bubble) begin
            q_ctrl <= BUBBLE;
            q_pay  <= '0;
        end else begin
            q_ctrl <= d_ctrl;
            q_pay  <= d_pay;
        end
    end

endmodule

// File: rtl/pipe_ctrl_tracker.sv
// Carries ID control bundles through EX/MEM/WB, returns hazard view, counts retirements.
// Optional operand forwarding is enabled by defining PIPE_FWD_EN.
module pipe_ctrl_tracker
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              ID_RF_WE,
    input  logic              ID_D_MEM_WEN,
    input  logic [1:0]        ID_REWR_MUX,
    input  logic              ID_NUMINSTADD,
    input  logic [REG_AW-1:0] ID_DEST,
    input  logic [REG_AW-1:0] ID_RS1,
    input  logic [REG_AW-1:0] ID_RS2,
    input  logic              STALL,
    input  logic              FLUSH,
    output logic [REG_AW-1:0] PREV_DEST,
    output logic [1:0]        PREV_REWR_MUX,
    output logic              MEM_D_MEM_WEN,
    output logic              WB_RF_WE,
    output logic [REG_AW-1:0] WB_DEST,
    output logic [1:0]        WB_REWR_MUX,
    output logic [1:0]        FWD_A,
    output logic [1:0]        FWD_B,
    output logic [CNT_W-1:0]  NUM_INST
);

`ifdef PIPE_FWD_EN
    localparam int EX_PW = 3 * REG_AW;
`else
    localparam int EX_PW = REG_AW;
`endif

    stage_ctrl_t       id_ctrl, ex_ctrl_p0, mem_ctrl_p1, wb_ctrl_p2;
    logic [EX_PW-1:0]  id_pay, ex_pay_p0;
    logic [REG_AW-1:0] ex_dest_p0, mem_dest_p1, wb_dest_p2;
    logic [CNT_W-1:0]  num_inst_q;
    logic              unused_wb;

    assign id_ctrl = '{
        valid:     1'b1,
        rf_we:     ID_RF_WE,
        d_mem_wen: ID_D_MEM_WEN,
        rewr_mux:  rewr_e'(ID_REWR_MUX),
        numinst:   ID_NUMINSTADD
    };

`ifdef PIPE_FWD_EN
    assign id_pay = {ID_DEST, ID_RS1, ID_RS2};
`else
    logic unused_rs;
    assign id_pay    = ID_DEST;
    assign unused_rs = ^{ID_RS1, ID_RS2};
`endif

    // ID -> EX: the only stage that can take a bubble
    pipe_ctrl_stage #(.PW(EX_PW)) u_ex (
        .clk    (CLK),
        .rst_n  (RSTn),
        .bubble (STALL | FLUSH),
        .d_ctrl (id_ctrl),
        .d_pay  (id_pay),
        .q_ctrl (ex_ctrl_p0),
        .q_pay  (ex_pay_p0)
    );

    assign ex_dest_p0 = ex_pay_p0[EX_PW-1 -: REG_AW];

    // EX -> MEM
    pipe_ctrl_stage #(.PW(REG_AW)) u_mem (
        .clk    (CLK),
        .rst_n  (RSTn),
        .bubble (1'b0),
        .d_ctrl (ex_ctrl_p0),
        .d_pay  (ex_dest_p0),
        .q_ctrl (mem_ctrl_p1),
        .q_pay  (mem_dest_p1)
    );

    // MEM -> WB
    pipe_ctrl_stage #(.PW(REG_AW)) u_wb (
        .clk    (CLK),
        .rst_n  (RSTn),
        .bubble (1'b0),
        .d_ctrl (mem_ctrl_p1),
        .d_pay  (mem_dest_p1),
        .q_ctrl (wb_ctrl_p2),
        .q_pay  (wb_dest_p2)
    );

    assign PREV_DEST     = ex_dest_p0;
    assign PREV_REWR_MUX = ex_ctrl_p0.rewr_mux;
    assign MEM_D_MEM_WEN = mem_ctrl_p1.d_mem_wen;
    assign WB_RF_WE      = wb_ctrl_p2.rf_we;
    assign WB_DEST       = wb_dest_p2;
    assign WB_REWR_MUX   = wb_ctrl_p2.rewr_mux;
    assign unused_wb     = wb_ctrl_p2.d_mem_wen;

`ifdef PIPE_FWD_EN
    // A load still in MEM has no data yet; that case is covered by the load-use stall.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input stage_ctrl_t       mem_c,
        input logic [REG_AW-1:0] mem_d,
        input stage_ctrl_t       wb_c,
        input logic [REG_AW-1:0] wb_d
    );
        if (mem_c.valid && mem_c.rf_we && (mem_d != '0) && (mem_d == rs) &&
            (mem_c.rewr_mux != REWR_LOAD))
            return FWD_MEM;
        if (wb_c.valid && wb_c.rf_we && (wb_d != '0) && (wb_d == rs))
            return FWD_WB;
        return FWD_RF;
    endfunction

    logic [REG_AW-1:0] ex_rs1_p0, ex_rs2_p0;
    assign ex_rs1_p0 = ex_pay_p0[2*REG_AW-1 -: REG_AW];
    assign ex_rs2_p0 = ex_pay_p0[REG_AW-1:0];

    assign FWD_A = fwd_sel(ex_rs1_p0, mem_ctrl_p1, mem_dest_p1, wb_ctrl_p2, wb_dest_p2);
    assign FWD_B = fwd_sel(ex_rs2_p0, mem_ctrl_p1, mem_dest_p1, wb_ctrl_p2, wb_dest_p2);
`else
    assign FWD_A = FWD_RF;
    assign FWD_B = FWD_RF;
`endif

    // Retire count: WB-stage instructions flagged as counting
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            num_inst_q <= '0;
        else if (wb_ctrl_p2.valid && wb_ctrl_p2.numinst)
            num_inst_q <= num_inst_q + CNT_W'(1);
    end

    assign NUM_INST = num_inst_q;

endmodule
